serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial two's-complement/unsigned adder that consumes one operand pair per request and produces the WIDTH-bit sum plus carry-out after WIDTH add cycles. It is the stage around the carry flip-flop in the datapath. Shift registers present one operand bit pair per clock, a full adder combines them with the stored carry, and a one-bit carry register feeds the carry back to the next bit. The block is the sequential arithmetic unit of the assignment-5 datapath and sits between the operand source (register file / testbench driver) and the result consumer.

## Interface
- WIDTH, 8, operand and sum width in bits (≥2)
- clk  input  1  rising-edge clock
- res  input  1  reset; asynchronous, active-low (res=0 resets immediately, independent of clk)
- start  input  1  request; sampled on rising clk edge, accepted only in IDLE
- a  input  WIDTH  operand A, captured on the accepting edge only
- b  input  WIDTH  operand B, captured on the accepting edge only
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, high while in DONE
- sum  output  WIDTH  registered result of last completed add
- cout  output  1  registered carry-out of last completed add

## Operation
- States: IDLE, RUN, DONE; reset state IDLE.
- Internal state: operand shift registers sa and sb (WIDTH bits each), carry register c (1 bit), partial-sum shift register ps (WIDTH bits), and a bit counter cnt (ceil(log2(WIDTH+1)) bits).
- IDLE with start=1:
  - sa←a, sb←b, c←0, ps←0, cnt←0.
  - Next state RUN.
- IDLE with start=0: all registers hold.
- RUN, each edge:
  - s = sa[0]^sb[0]^c.
  - c←(sa[0]&sb[0])|(c&(sa[0]^sb[0])).
  - ps←{s, ps[WIDTH-1:1]}, so the LSB is computed first and enters at the MSB.
  - sa←sa>>1, sb←sb>>1, cnt←cnt+1.
- RUN, when cnt==WIDTH-1 at the edge:
  - Perform the final bit step.
  - sum←{s, ps[WIDTH-1:1]}, cout←carry from that step.
  - Next state DONE.
- DONE: one cycle only, then IDLE unconditionally. start is ignored in DONE.
- start while in RUN or DONE: ignored. Operands are not re-captured and there is no queuing.
- Overflow: the sum wraps modulo 2^WIDTH. Unsigned overflow is reported only via cout. No signed-overflow flag.
- sum and cout change only on the RUN→DONE edge or on reset. They hold all other times, including during a subsequent RUN.
- a and b may change freely after the accepting edge without affecting the result.

## Timing
- Reset (res=0, asynchronous): state=IDLE, busy=0, done=0, sum=0, cout=0, and sa, sb, c, ps, cnt all cleared.
- Reset release: first accepted start is on the first rising edge with res=1 and start=1.
- Reset mid-operation:
  - The operation is aborted immediately.
  - No done pulse is produced, and sum/cout are zeroed (not the partial result).
- Latency, with start accepted at edge E0:
  - busy=1 from after E0 through E_WIDTH.
  - State DONE after E_WIDTH, so done=1 between E_WIDTH and E_WIDTH+1.
  - sum/cout are valid from E_WIDTH onward.
- Throughput: one add per WIDTH+2 cycles with start held high, because a new request is accepted in IDLE on edge E_WIDTH+2.
- busy and done are mutually exclusive and never both high.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Basic add (WIDTH=8): res low 2 cycles, then a=8'h0F, b=8'h01, start pulse. Required: busy high 8 cycles, then done for 1 cycle, sum=8'h10, cout=0.
- Carry-out and wrap: a=8'hFF, b=8'h01 gives sum=8'h00, cout=1. a=8'hFF, b=8'hFF gives sum=8'hFE, cout=1. a=8'h00, b=8'h00 gives sum=8'h00, cout=0.
- Ignored start and operand change:
  - Stimulus: start a=8'h12, b=8'h34; during RUN, pulse start with a=8'hAA, b=8'h55 and change the a/b pins.
  - Required: sum=8'h46, cout=0, exactly one done pulse.
  - Required: sum/cout keep their prior values until the completing edge.
- Async reset mid-op:
  - Stimulus: start a=8'h80, b=8'h80; drop res between clk edges after 4 RUN cycles.
  - Required: busy, done, sum and cout go 0 immediately without a clock edge, and no done pulse follows.
  - Then start a=8'h80, b=8'h80 again. Required: sum=8'h00, cout=1.
- Back-to-back: hold start=1 with a=8'h01, b=8'h02, changing to a=8'h03, b=8'h04 after the first accept. Required: done pulses WIDTH+2 cycles apart, results 8'h03 then 8'h07.
- Random regression: 1000 random a/b pairs compared against the {cout,sum}=a+b model, also run at WIDTH=4 and WIDTH=16.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit pair per clock through a full adder and a carry flip-flop.
// Accepts a request in IDLE, runs WIDTH bit steps in RUN, then pulses done for one cycle.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t stateNext;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] ps;
    logic             c;
    logic [CW-1:0]    cnt;

    logic bitSum;
    logic bitCarry;
    logic lastBit;

    assign bitSum   = sa[0] ^ sb[0] ^ c;
    assign bitCarry = (sa[0] & sb[0]) | (c & (sa[0] ^ sb[0]));
    assign lastBit  = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = RUN;
            RUN:     if (lastBit) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Each sum bit enters ps at the MSB, so after WIDTH steps the LSB has shifted down to bit 0.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            sa   <= '0;
            sb   <= '0;
            ps   <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        ps  <= '0;
                        c   <= 1'b0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    c   <= bitCarry;
                    ps  <= {bitSum, ps[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (lastBit) begin
                        sum  <= {bitSum, ps[WIDTH-1:1]};
                        cout <= bitCarry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random bench for serial_adder at WIDTH 8, with WIDTH 4 and 16 instances
// sharing clock and reset for the wide/narrow random regression.
module tb_serial_adder;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        busy, done, cout;
    logic [7:0]  sum;

    logic        start4 = 1'b0;
    logic [3:0]  a4 = '0;
    logic [3:0]  b4 = '0;
    logic        busy4, done4, cout4;
    logic [3:0]  sum4;

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        busy16, done16, cout16;
    logic [15:0] sum16;

    int checks = 0;
    int errors = 0;
    int overlapCnt = 0;

    logic [7:0] obsSum;
    logic       obsCout;
    int         busyCycles;
    int         doneCount;
    int         holdErrs;
    logic [7:0] heldSum = '0;
    logic       heldCout = 1'b0;

    vec_t vecs[8];

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .res(res), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder #(.WIDTH(4)) u4 (
        .clk(clk), .res(res), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    serial_adder #(.WIDTH(16)) u16 (
        .clk(clk), .res(res), .start(start16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ((busy && done) || (busy4 && done4) || (busy16 && done16)) overlapCnt++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // One 8-bit transaction; operands are scrambled right after the accepting edge.
    task automatic applyStimulus(input logic [7:0] ia, input logic [7:0] ib, input bit midStart);
        @(negedge clk);
        a = ia;
        b = ib;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~ia;
        b = ~ib;
        busyCycles = 0;
        doneCount = 0;
        holdErrs = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            if (busy) busyCycles++;
            if (sum !== heldSum || cout !== heldCout) holdErrs++;
            if (midStart && n == 2) begin
                start = 1'b1;
                a = 8'hAA;
                b = 8'h55;
            end else if (midStart && n == 3) begin
                start = 1'b0;
                a = 8'h3C;
            end
            @(negedge clk);
        end
        obsSum = sum;
        obsCout = cout;
        if (done) doneCount = 1;
        @(negedge clk);
        if (done) doneCount++;
    endtask

    task automatic checkTransaction(input string name, input logic [7:0] expSum, input logic expCout);
        checkOutput({name, "_sum"}, 32'(obsSum), 32'(expSum));
        checkOutput({name, "_cout"}, 32'(obsCout), 32'(expCout));
        checkOutput({name, "_busy_cycles"}, 32'(busyCycles), 32'd8);
        checkOutput({name, "_done_pulses"}, 32'(doneCount), 32'd1);
        checkOutput({name, "_hold"}, 32'(holdErrs), 32'd0);
        heldSum = expSum;
        heldCout = expCout;
    endtask

    task automatic runWide(input logic [3:0] ia4, input logic [3:0] ib4,
                           input logic [15:0] ia16, input logic [15:0] ib16);
        logic        got4;
        logic        got16;
        logic [4:0]  res4;
        logic [16:0] res16;
        got4 = 1'b0;
        got16 = 1'b0;
        res4 = '0;
        res16 = '0;
        @(negedge clk);
        a4 = ia4;  b4 = ib4;  start4 = 1'b1;
        a16 = ia16; b16 = ib16; start16 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;  a4 = ~ia4;   b4 = ~ib4;
        start16 = 1'b0; a16 = ~ia16; b16 = ~ib16;
        for (int n = 0; n < 60 && !(got4 && got16); n++) begin
            if (done4 && !got4) begin
                got4 = 1'b1;
                res4 = {cout4, sum4};
            end
            if (done16 && !got16) begin
                got16 = 1'b1;
                res16 = {cout16, sum16};
            end
            if (!(got4 && got16)) @(negedge clk);
        end
        checkOutput("rand4", got4 ? 32'(res4) : 32'hDEAD_0004, 32'({1'b0, ia4} + {1'b0, ib4}));
        checkOutput("rand16", got16 ? 32'(res16) : 32'hDEAD_0016, 32'({1'b0, ia16} + {1'b0, ib16}));
    endtask

    initial begin
        int         d1;
        int         d2;
        int         lateDone;
        logic [7:0] s1;
        logic [7:0] s2;
        logic [7:0] ra;
        logic [7:0] rb;

        vecs[0] = '{8'h0F, 8'h01, 8'h10, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{8'h7F, 8'h01, 8'h80, 1'b0};
        vecs[5] = '{8'hAA, 8'h55, 8'hFF, 1'b0};
        vecs[6] = '{8'h80, 8'h80, 8'h00, 1'b1};
        vecs[7] = '{8'hC8, 8'h64, 8'h2C, 1'b1};

        repeat (2) @(negedge clk);
        checkOutput("reset_state8", 32'({busy, done, cout, sum}), 32'd0);
        checkOutput("reset_state_wide", 32'({busy4, done4, busy16, done16, cout4, cout16, sum4, sum16}), 32'd0);
        res = 1'b1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, 1'b0);
            checkTransaction($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cout);
        end

        // start pulsed mid-run with new operands must be ignored
        applyStimulus(8'h12, 8'h34, 1'b1);
        repeat (12) begin
            @(negedge clk);
            if (done) doneCount++;
        end
        checkTransaction("ignored_start", 8'h46, 1'b0);

        applyStimulus(8'hFF, 8'hFF, 1'b0);
        checkTransaction("pre_reset", 8'hFE, 1'b1);

        // asynchronous reset four cycles into a run
        @(negedge clk);
        a = 8'h80;
        b = 8'h80;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 res = 1'b0;
        #1 checkOutput("async_reset_outputs", 32'({busy, done, cout, sum}), 32'd0);
        @(negedge clk);
        res = 1'b1;
        lateDone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) lateDone++;
        end
        checkOutput("no_done_after_reset", 32'(lateDone), 32'd0);
        heldSum = 8'h00;
        heldCout = 1'b0;
        applyStimulus(8'h80, 8'h80, 1'b0);
        checkTransaction("after_reset", 8'h00, 1'b1);

        // back-to-back with start held high
        @(negedge clk);
        a = 8'h01;
        b = 8'h02;
        start = 1'b1;
        @(negedge clk);
        a = 8'h03;
        b = 8'h04;
        d1 = -1;
        d2 = -1;
        s1 = '0;
        s2 = '0;
        for (int n = 1; n <= 40 && d2 < 0; n++) begin
            if (done) begin
                if (d1 < 0) begin
                    d1 = n;
                    s1 = sum;
                end else begin
                    d2 = n;
                    s2 = sum;
                    start = 1'b0;
                end
            end
            if (d2 < 0) @(negedge clk);
        end
        start = 1'b0;
        checkOutput("b2b_first_sum", 32'(s1), 32'h03);
        checkOutput("b2b_second_sum", 32'(s2), 32'h07);
        checkOutput("b2b_spacing", (d1 < 0 || d2 < 0) ? 32'hFFFF_FFFF : 32'(d2 - d1), 32'd10);
        repeat (15) @(negedge clk);
        heldSum = 8'h07;
        heldCout = 1'b0;

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            applyStimulus(ra, rb, 1'b0);
            checkOutput("rand8", 32'({obsCout, obsSum}), 32'({1'b0, ra} + {1'b0, rb}));
            checkOutput("rand8_done", 32'(doneCount), 32'd1);
            heldSum = obsSum;
            heldCout = obsCout;
        end

        for (int i = 0; i < 300; i++) begin
            runWide(4'($urandom), 4'($urandom), 16'($urandom), 16'($urandom));
        end

        checkOutput("busy_done_exclusive", 32'(overlapCnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
